// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, radix-2 shift-add multiply and restoring divide.
// Latency: start at E0, 32 iterations E1..E32, one-cycle done/we3 pulse between E32 and E33.
// Backpressure: busy holds the pipeline; start is ignored while busy. MULDIV_EARLY_OUT_EN: div-by-zero/overflow finish at E0.
// Ports: clk, reset (sync, active-high), start/funct3/srca/srcb/rd request in; busy, done, we3/a3/wd3 write request out.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic [4:0]      rd,
    output logic            busy,
    output logic            done,
    output logic            we3,
    output logic [4:0]      a3,
    output logic [XLEN-1:0] wd3
);

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic EARLY_OUT = 1'b1;
`else
    localparam logic EARLY_OUT = 1'b0;
`endif

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;       // multiply: {hi, multiplier}; divide: {rem, quo}
    logic [XLEN-1:0]     opnd_q, opnd_d;     // |multiplicand| or |divisor|
    logic [2:0]          f3_q, f3_d;
    logic [4:0]          rd_q, rd_d;
    logic                neg_q, neg_d;       // product/quotient sign
    logic                aneg_q, aneg_d;     // remainder follows dividend sign
    logic                spec_q, spec_d;     // divide special case, result substituted
    logic [XLEN-1:0]     spec_res_q, spec_res_d;

    // Request decode (only meaningful in the start cycle)
    logic            a_sgn, b_sgn, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0] a_abs, b_abs;

    assign a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
    assign b_sgn = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    assign a_neg = a_sgn && srca[XLEN-1];
    assign b_neg = b_sgn && srcb[XLEN-1];
    assign a_abs = a_neg ? -srca : srca;
    assign b_abs = b_neg ? -srcb : srcb;
    assign div0  = funct3[2] && (srcb == '0);
    assign ovf   = funct3[2] && !funct3[0] && (srca == INT_MIN) && (srcb == '1);

    // One multiply step: conditional add into the upper half, then shift right
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    assign mul_sum = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q})
                              : {1'b0, acc_q[2*XLEN-1:XLEN]};
    assign mul_nxt = {mul_sum, acc_q[XLEN-1:1]};

    // One restoring divide step: shift {rem,quo} left, subtract divisor if it fits
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] div_nxt;
    assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign div_ge   = div_sh >= {1'b0, opnd_q};
    assign div_diff = div_sh[XLEN-1:0] - opnd_q;
    assign div_nxt  = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                             : {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        neg_d      = neg_q;
        aneg_d     = aneg_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d       = funct3;
                    rd_d       = rd;
                    neg_d      = a_neg ^ b_neg;
                    aneg_d     = a_neg;
                    cnt_d      = '0;
                    acc_d      = {{XLEN{1'b0}}, a_abs};
                    opnd_d     = b_abs;
                    spec_d     = div0 || ovf;
                    if (funct3[1])
                        spec_res_d = div0 ? srca : '0;
                    else
                        spec_res_d = div0 ? '1 : INT_MIN;
                    state_d    = (EARLY_OUT && (div0 || ovf)) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                acc_d = f3_q[2] ? div_nxt : mul_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN-1))
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            aneg_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            neg_q      <= neg_d;
            aneg_q     <= aneg_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
        end
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_s, rem_s, res;
    assign prod  = neg_q  ? -acc_q : acc_q;
    assign quo_s = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_s = aneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        res = '0;
        if (spec_q)
            res = spec_res_q;
        else if (!f3_q[2])
            res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else
            res = f3_q[1] ? rem_s : quo_s;
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
        we3  = done;
        a3   = '0;
        wd3  = '0;
        if (done) begin
            a3  = rd_q;
            wd3 = res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with a per-cycle arithmetic reference model.
// Latency: model expects done 32 cycles after acceptance (1 for special divides with early-out).
// Backpressure: model drops start requests that arrive while it believes the unit busy.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk, reset, start;
    logic [2:0]  funct3;
    logic [31:0] srca, srcb;
    logic [4:0]  rd;
    logic        busy, done, we3;
    logic [4:0]  a3;
    logic [31:0] wd3;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .srca(srca), .srcb(srcb), .rd(rd),
        .busy(busy), .done(done), .we3(we3), .a3(a3), .wd3(wd3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Architectural result of an RV32M operation
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Model: accepted operation occupies cycles [exp_start, exp_done], write in exp_done
    int          cyc = 0;
    int          exp_start = 0;
    int          exp_done = -1;
    logic [4:0]  exp_a3 = '0;
    logic [31:0] exp_wd3 = '0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            exp_start = 0;
            exp_done  = -1;
        end else if (start && !(cyc >= exp_start && cyc <= exp_done)) begin
            exp_start = cyc + 1;
            exp_done  = cyc + 1 + ((EARLY && is_special(funct3, srca, srcb)) ? 0 : 32);
            exp_a3    = rd;
            exp_wd3   = ref_result(funct3, srca, srcb);
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (started) begin
            logic e_busy, e_we;
            e_busy = (cyc >= exp_start) && (cyc <= exp_done);
            e_we   = (cyc == exp_done);
            checks++;
            if (busy !== e_busy || we3 !== e_we || done !== e_we) begin
                errors++;
                $display("FAIL cyc_ctrl @%0d: busy=%b we3=%b done=%b required busy=%b we3=%b", cyc, busy, we3, done, e_busy, e_we);
            end
            checks++;
            if (a3 !== (e_we ? exp_a3 : 5'd0) || wd3 !== (e_we ? exp_wd3 : 32'd0)) begin
                errors++;
                $display("FAIL cyc_data @%0d: a3=%0d wd3=%h required a3=%0d wd3=%h", cyc, a3, wd3,
                         e_we ? exp_a3 : 5'd0, e_we ? exp_wd3 : 32'd0);
            end
        end
    end

    // Issue one operation at the current negedge and wait for its write
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] lit, input string name);
        int k;
        bit seen;
        int exp_k;
        funct3 = f; srca = a; srcb = b; rd = r; start = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                srca  = $urandom;
                srcb  = $urandom;
                rd    = 5'($urandom);
            end
            if (we3) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no we3 within %0d cycles, required a write", name, k);
        end else begin
            checks++;
            if (wd3 !== lit) begin
                errors++;
                $display("FAIL %s_wd3: got %h required %h", name, wd3, lit);
            end
            checks++;
            if (a3 !== r) begin
                errors++;
                $display("FAIL %s_a3: got %0d required %0d", name, a3, r);
            end
            exp_k = (EARLY && is_special(f, a, b)) ? 1 : 33;
            checks++;
            if (k != exp_k) begin
                errors++;
                $display("FAIL %s_latency: done at negedge %0d required %0d", name, k, exp_k);
            end
        end
        checks++;
        if (ref_result(f, a, b) !== lit) begin
            errors++;
            $display("FAIL %s_model: model %h required %h", name, ref_result(f, a, b), lit);
        end
    endtask

    localparam int NV = 18;
    logic [2:0]  v_f   [NV] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5,
                                3'd6, 3'd4, 3'd6, 3'd1, 3'd4, 3'd7, 3'd5, 3'd0, 3'd2};
    logic [31:0] v_a   [NV] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000,
                                32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFF9, 32'h80000000,
                                32'd12345, 32'd2};
    logic [31:0] v_b   [NV] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'h80000000, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1000, 32'hFFFFFFFF};
    logic [4:0]  v_rd  [NV] = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13,
                                5'd14, 5'd15, 5'd16, 5'd0, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21};
    logic [31:0] v_exp [NV] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                32'hFFFFFFFF, 32'h0000000E, 32'h00000002, 32'hFFFFFFFF, 32'h00000005,
                                32'h80000000, 32'h00000000, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                32'h00000000, 32'h00BC5EA8, 32'h00000001};

    initial begin
        int k;
        bit seen;
        reset = 1'b1; start = 1'b0; funct3 = '0; srca = '0; srcb = '0; rd = '0;
        repeat (3) @(negedge clk);
        started = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b we3=%b a3=%0d wd3=%h required all zero", busy, done, we3, a3, wd3);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_op(v_f[i], v_a[i], v_b[i], v_rd[i], v_exp[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // DIVU 9/3 with a MUL 3x4 request arriving while busy
        funct3 = 3'd5; srca = 32'd9; srcb = 32'd3; rd = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        funct3 = 3'd0; srca = 32'd3; srcb = 32'd4; rd = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            if (we3) seen = 1'b1;
            else begin @(negedge clk); k++; end
        end
        checks++;
        if (!seen || wd3 !== 32'd3 || a3 !== 5'd3) begin
            errors++;
            $display("FAIL busy_ignore: seen=%b a3=%0d wd3=%h required a3=3 wd3=00000003", seen, a3, wd3);
        end
        @(negedge clk);
        run_op(3'd0, 32'd3, 32'd4, 5'd4, 32'd12, "after_done");
        @(negedge clk);

        // Reset in the middle of CALC
        funct3 = 3'd4; srca = 32'd1000; srcb = 32'd7; rd = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wd3 !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b wd3=%h required 0 0 00000000", busy, done, wd3);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (we3) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_reset_no_write: we3 seen=%b required 0", seen);
        end
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd1, 32'hFFFFFFFF, "post_reset");
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
